// File: rtl/ql_bus_initiator_pkg.sv
// Shared definitions for the QL 68008 expansion-bus initiator: FSM states,
// default bus geometry, the abandon timeout and the idle level of the strobes.
package ql_bus_initiator_pkg;

  localparam int unsigned QL_ADDR_W      = 20;
  localparam int unsigned QL_DATA_W      = 8;
  localparam int unsigned QL_TIMEOUT_CYC = 64;

  // Negated level of asl/dsl/rdwl (all active low on the 68008 bus)
  localparam logic STROBE_IDLE = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ASRT,
    ST_DSW,
    ST_WAIT,
    ST_LATCH,
    ST_REL,
    ST_ABRT,
    ST_FIN
  } bus_state_e;

endpackage

// File: rtl/ql_bus_initiator_sync2.sv
// Two-flop synchronizer for an asynchronous active-low bus input; resets to
// the negated level so a held reset never looks like an acknowledge.
module ql_sync2 (
  input  logic clk,
  input  logic rstl,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // the values from before the edge, giving two real stages instead of one.
  always_ff @(posedge clk or negedge rstl) begin
    if (!rstl) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/ql_bus_initiator.sv
// Single-beat 8-bit master for the QL 68008 expansion bus: runs one AS/DS/RDW
// cycle per request, completing on DTACK or abandoning after a bounded wait.
module ql_bus_initiator
  import ql_bus_initiator_pkg::*;
#(
  parameter int unsigned ADDR_W      = QL_ADDR_W,
  parameter int unsigned DATA_W      = QL_DATA_W,
  parameter int unsigned TIMEOUT_CYC = QL_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              rstl,
  input  logic              req,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  input  logic [DATA_W-1:0] data_in,
  output logic              asl,
  output logic              dsl,
  output logic              rdwl,
  input  logic              dtackl
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  bus_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              tmo_q, tmo_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              asl_q, asl_d, dsl_q, dsl_d, rdwl_q, rdwl_d;
  logic              oe_q, oe_d, busy_q, busy_d, done_q, done_d, timeout_q, timeout_d;
  logic              dtk_s;
  logic              cnt_last;

  ql_sync2 u_dtk_sync (
    .clk  (clk),
    .rstl (rstl),
    .d    (dtackl),
    .q    (dtk_s)
  );

  assign cnt_last = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rstl) begin
    if (!rstl) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      tmo_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      asl_q     <= STROBE_IDLE;
      dsl_q     <= STROBE_IDLE;
      rdwl_q    <= STROBE_IDLE;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      tmo_q     <= tmo_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      asl_q     <= asl_d;
      dsl_q     <= dsl_d;
      rdwl_q    <= rdwl_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  // NOTE: every combinational output gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (req) state_d = ST_ADDR;
      ST_ADDR:  state_d = ST_ASRT;
      ST_ASRT:  state_d = we_q ? ST_DSW : ST_WAIT;
      ST_DSW:   state_d = ST_WAIT;
      ST_WAIT: begin
        if (!dtk_s)        state_d = ST_LATCH;
        else if (cnt_last) state_d = ST_ABRT;
      end
      ST_LATCH: state_d = ST_REL;
      ST_REL:   if (dtk_s || cnt_last) state_d = ST_FIN;
      ST_ABRT:  state_d = ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Bus outputs are registered from the next state so each pin is stable for
  // the whole cycle of the state that owns it.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    tmo_d   = tmo_q;
    cnt_d   = '0;

    if (state_q == ST_IDLE && req) begin
      addr_d  = req_addr;
      wdata_d = req_wdata;
      we_d    = req_we;
      tmo_d   = 1'b0;
    end
    if (state_q == ST_WAIT || state_q == ST_REL)
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    if (state_q == ST_LATCH && !we_q)
      rdata_d = data_in;
    // A release phase that runs out without DTACK negating still counts as abandoned
    if (state_d == ST_ABRT || (state_q == ST_REL && state_d == ST_FIN && !dtk_s))
      tmo_d = 1'b1;

    busy_d    = state_d inside {ST_ADDR, ST_ASRT, ST_DSW, ST_WAIT, ST_LATCH, ST_REL, ST_ABRT};
    asl_d     = !(state_d inside {ST_ASRT, ST_DSW, ST_WAIT});
    dsl_d     = !((state_d == ST_ASRT && !we_d) || state_d inside {ST_DSW, ST_WAIT});
    rdwl_d    = busy_d ? !we_d : STROBE_IDLE;
    oe_d      = busy_d && we_d;
    done_d    = (state_d == ST_FIN);
    timeout_d = (state_d == ST_FIN) && tmo_d;
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign timeout  = timeout_q;
  assign rdata    = rdata_q;
  assign address  = addr_q;
  assign data_out = wdata_q;
  assign data_oe  = oe_q;
  assign asl      = asl_q;
  assign dsl      = dsl_q;
  assign rdwl     = rdwl_q;

endmodule
